// File: rtl/cr_huf_comp_is_reader_pkg.sv
// ============================================================================
// cr_structs / cr_huf_compPKG : shared types for the sorted-table reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 4
`endif

package cr_structs;
  typedef enum logic [1:0] {
    MIDDLE    = 2'd0,
    LAST      = 2'd1,
    PASS_THRU = 2'd2,
    MEMBER    = 2'd3
  } e_pipe_eob;
endpackage

package cr_huf_compPKG;
  import cr_structs::*;

  localparam int IS_RD_DAT_W  = 10;
  localparam int IS_RD_FREQ_W = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    MARK   = 2'd2
  } e_is_rd_state;

  typedef struct packed {
    logic [IS_RD_DAT_W-1:0]  sym;
    logic [IS_RD_FREQ_W-1:0] freq;
    logic                    last;
    logic                    empty;
    e_pipe_eob               eob;
  } is_rd_beat_t;

  localparam is_rd_beat_t IS_RD_BEAT_IDLE = '{sym: '0, freq: '0, last: 1'b0,
                                              empty: 1'b0, eob: MIDDLE};
endpackage

`default_nettype wire

// File: rtl/cr_huf_comp_is_reader_chk.sv
// ============================================================================
// cr_huf_comp_is_reader_chk : sticky order checker on accepted reader beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cr_huf_comp_is_reader_chk #(
  parameter int SYM_FREQ_WIDTH = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_accept,
  input  logic                      i_empty,
  input  logic                      i_last,
  input  logic [SYM_FREQ_WIDTH-1:0] i_freq,
  output logic                      o_order_err
);

  logic [SYM_FREQ_WIDTH-1:0] r_prev_freq;
  logic                      r_prev_vld;
  logic                      r_err;
  logic                      w_zero_err;
  logic                      w_desc_err;

  assign w_zero_err = i_accept && !i_empty && (i_freq == '0);
  assign w_desc_err = i_accept && r_prev_vld && (i_freq < r_prev_freq);

  // r_prev_vld drops on the last beat so a new block never compares to the old one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_freq <= '0;
      r_prev_vld  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_zero_err || w_desc_err) r_err <= 1'b1;
      if (i_accept) begin
        r_prev_freq <= i_freq;
        r_prev_vld  <= !i_last;
      end
    end
  end

  assign o_order_err = r_err;

endmodule

`default_nettype wire

// File: rtl/cr_huf_comp_is_reader.sv
// ============================================================================
// cr_huf_comp_is_reader : captures a sorted table and streams nonzero entries.
// Optional order checker: CR_HUF_COMP_IS_READER_CHECK_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 4
`endif

module cr_huf_comp_is_reader
  import cr_structs::*;
  import cr_huf_compPKG::*;
#(
  parameter int DAT_WIDTH        = 10,
  parameter int SYM_FREQ_WIDTH   = 15,
  parameter int CNTRL_WIDTH      = 1,
  parameter int MAX_NUM_SYM_USED = 576
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [DAT_WIDTH-1:0]                             is_ht_sym_lo,
  input  logic [DAT_WIDTH-1:0]                             is_ht_sym_hi,
  input  logic [DAT_WIDTH-1:0]                             is_ht_sym_unique,
  input  logic [MAX_NUM_SYM_USED-1:0][SYM_FREQ_WIDTH-1:0]  is_ht_sym_sort_freq,
  input  logic [MAX_NUM_SYM_USED-1:0][DAT_WIDTH-1:0]       is_ht_sym_sort_freq_sym,
  input  logic [CNTRL_WIDTH-1:0]                           is_ht_meta,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0]                is_ht_seq_id,
  input  e_pipe_eob                                        is_ht_eob,
  output logic                                             ht_is_not_ready,
  input  logic                                             rd_ready,
  output logic                                             rd_valid,
  output logic [DAT_WIDTH-1:0]                             rd_sym,
  output logic [SYM_FREQ_WIDTH-1:0]                        rd_freq,
  output logic                                             rd_last,
  output logic                                             rd_empty,
  output e_pipe_eob                                        rd_eob,
  output logic [CNTRL_WIDTH-1:0]                           rd_meta,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0]                rd_seq_id,
  output logic [DAT_WIDTH-1:0]                             rd_sym_lo,
  output logic [DAT_WIDTH-1:0]                             rd_sym_hi,
  output logic                                             rd_overrun,
  output logic                                             rd_order_err
);

  localparam int PTR_W = DAT_WIDTH + 1;
  localparam logic [PTR_W-1:0] c_MAX  = PTR_W'(MAX_NUM_SYM_USED);
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(MAX_NUM_SYM_USED - 1);

  e_is_rd_state r_state, w_state_nxt;

  logic [MAX_NUM_SYM_USED-1:0][SYM_FREQ_WIDTH-1:0] r_freq_sh;
  logic [MAX_NUM_SYM_USED-1:0][DAT_WIDTH-1:0]      r_sym_sh;
  logic [CNTRL_WIDTH-1:0]                          r_meta;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0]               r_seq_id;
  logic [DAT_WIDTH-1:0]                            r_sym_lo;
  logic [DAT_WIDTH-1:0]                            r_sym_hi;
  e_pipe_eob                                       r_eob_sh;

  logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_ptr_inc, w_unique_ext;
  is_rd_beat_t      r_beat, w_beat_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_overrun;
  logic             w_capture, w_empty_blk, w_accept;

  assign w_unique_ext = {1'b0, is_ht_sym_unique};
  assign w_ptr_inc    = r_ptr + 1'b1;
  assign w_capture    = (r_state == IDLE) && (is_ht_eob != MIDDLE);
  assign w_empty_blk  = (w_unique_ext >= c_MAX);
  assign w_accept     = r_valid && rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // First beat comes straight from the inputs since the shadows load on the same edge
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = w_unique_ext;
          if (w_empty_blk) begin
            w_state_nxt = MARK;
            w_beat_nxt  = '{sym: '0, freq: '0, last: 1'b1, empty: 1'b1, eob: is_ht_eob};
          end else begin
            w_state_nxt      = STREAM;
            w_beat_nxt.sym   = is_ht_sym_sort_freq_sym[is_ht_sym_unique];
            w_beat_nxt.freq  = is_ht_sym_sort_freq[is_ht_sym_unique];
            w_beat_nxt.last  = (w_unique_ext == c_LAST);
            w_beat_nxt.empty = 1'b0;
            w_beat_nxt.eob   = (w_unique_ext == c_LAST) ? is_ht_eob : MIDDLE;
          end
        end
      end
      STREAM: begin
        if (w_accept) begin
          if (r_beat.last) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_beat_nxt  = IS_RD_BEAT_IDLE;
          end else begin
            w_ptr_nxt        = w_ptr_inc;
            w_beat_nxt.sym   = r_sym_sh[w_ptr_inc[DAT_WIDTH-1:0]];
            w_beat_nxt.freq  = r_freq_sh[w_ptr_inc[DAT_WIDTH-1:0]];
            w_beat_nxt.last  = (w_ptr_inc == c_LAST);
            w_beat_nxt.empty = 1'b0;
            w_beat_nxt.eob   = (w_ptr_inc == c_LAST) ? r_eob_sh : MIDDLE;
          end
        end
      end
      MARK: begin
        if (w_accept) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_beat_nxt  = IS_RD_BEAT_IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat  <= IS_RD_BEAT_IDLE;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_beat  <= w_beat_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_freq_sh <= '0;
      r_sym_sh  <= '0;
      r_meta    <= '0;
      r_seq_id  <= '0;
      r_sym_lo  <= '0;
      r_sym_hi  <= '0;
      r_eob_sh  <= MIDDLE;
    end else if (w_capture) begin
      r_freq_sh <= is_ht_sym_sort_freq;
      r_sym_sh  <= is_ht_sym_sort_freq_sym;
      r_meta    <= is_ht_meta;
      r_seq_id  <= is_ht_seq_id;
      r_sym_lo  <= is_ht_sym_lo;
      r_sym_hi  <= is_ht_sym_hi;
      r_eob_sh  <= is_ht_eob;
    end
  end

  // A strobe while busy is dropped; only the sticky flag records it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_overrun <= 1'b0;
    else if ((r_state != IDLE) && (is_ht_eob != MIDDLE)) r_overrun <= 1'b1;
  end

`ifdef CR_HUF_COMP_IS_READER_CHECK_EN
  cr_huf_comp_is_reader_chk #(
    .SYM_FREQ_WIDTH (SYM_FREQ_WIDTH)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .i_accept    (w_accept),
    .i_empty     (r_beat.empty),
    .i_last      (r_beat.last),
    .i_freq      (r_beat.freq),
    .o_order_err (rd_order_err)
  );
`else
  assign rd_order_err = 1'b0;
`endif

  assign ht_is_not_ready = (r_state != IDLE);
  assign rd_valid        = r_valid;
  assign rd_sym          = r_beat.sym;
  assign rd_freq         = r_beat.freq;
  assign rd_last         = r_beat.last;
  assign rd_empty        = r_beat.empty;
  assign rd_eob          = r_beat.eob;
  assign rd_meta         = r_meta;
  assign rd_seq_id       = r_seq_id;
  assign rd_sym_lo       = r_sym_lo;
  assign rd_sym_hi       = r_sym_hi;
  assign rd_overrun      = r_overrun;

endmodule

`default_nettype wire
